// File: rtl/window_discriminator.sv
// Multi-channel SCA window discriminator with hysteretic level outputs and pulse qualification.
// Optional peak capture of accepted events is enabled by defining WD_PEAK_CAPTURE_EN.
module window_discriminator #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NCH              = 2,
  parameter int HYST             = 10,
  parameter int MIN_WIDTH        = 4,
  parameter int CNT_WIDTH        = 32
) (
  input  logic                          adc_clk,
  input  logic                          rst,
  input  logic [NCH*AXIS_TDATA_WIDTH-1:0] adc_dat,
  input  logic [NCH*ADC_WIDTH-1:0]      thr_low,
  input  logic [NCH*ADC_WIDTH-1:0]      thr_high,
  input  logic                          clr_cnt,
  output logic [NCH-1:0]                vgl,
  output logic [NCH-1:0]                vgh,
  output logic [NCH-1:0]                evt_valid,
  output logic [NCH-1:0]                evt_reject,
  output logic [NCH*CNT_WIDTH-1:0]      evt_cnt,
  output logic [NCH*ADC_WIDTH-1:0]      peak
);

  // state  | meaning
  // IDLE   | below window, waiting for a rising crossing of thr_low+HYST
  // PULSE  | in window, width counted up to MIN_WIDTH
  // OVER   | pulse crossed thr_high+HYST, will be rejected when it falls
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_OVER} state_t;

  localparam int CW = ADC_WIDTH + 2;
  localparam int WW = $clog2(MIN_WIDTH + 1);
  localparam logic [WW-1:0]        WMAX   = WW'(MIN_WIDTH);
  localparam logic signed [CW-1:0] HYST_C = CW'(HYST);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic signed [ADC_WIDTH-1:0] d_s, tl_s, th_s;
    logic signed [CW-1:0]        d_x, tl_x, th_x;
    logic                        rise_l, fall_l, rise_h, fall_h;
    state_t                      state_q, state_d;
    logic [WW-1:0]               width_q, width_d;
    logic                        valid_d, reject_d;
    logic                        vgl_q, vgh_q, valid_q, reject_q;
    logic [CNT_WIDTH-1:0]        cnt_q;

    assign d_s  = adc_dat[c*AXIS_TDATA_WIDTH +: ADC_WIDTH];
    assign tl_s = thr_low[c*ADC_WIDTH +: ADC_WIDTH];
    assign th_s = thr_high[c*ADC_WIDTH +: ADC_WIDTH];

    if (AXIS_TDATA_WIDTH > ADC_WIDTH) begin : g_pad
      logic unused_lane_bits;
      assign unused_lane_bits = ^adc_dat[c*AXIS_TDATA_WIDTH+ADC_WIDTH +: AXIS_TDATA_WIDTH-ADC_WIDTH];
    end

    // Two guard bits so that threshold+HYST cannot wrap at full scale.
    assign d_x  = {{2{d_s[ADC_WIDTH-1]}}, d_s};
    assign tl_x = {{2{tl_s[ADC_WIDTH-1]}}, tl_s};
    assign th_x = {{2{th_s[ADC_WIDTH-1]}}, th_s};

    assign rise_l = d_x > (tl_x + HYST_C);
    assign fall_l = d_x < tl_x;
    assign rise_h = d_x > (th_x + HYST_C);
    assign fall_h = d_x < th_x;

    always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      valid_d  = 1'b0;
      reject_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise_l) begin
            width_d = WW'(1);
            state_d = rise_h ? S_OVER : S_PULSE;
          end
        end
        S_PULSE: begin
          if (fall_l) begin
            state_d = S_IDLE;
            width_d = '0;
            if (width_q >= WMAX) valid_d = 1'b1;
            else                 reject_d = 1'b1;
          end else if (rise_h) begin
            state_d = S_OVER;
          end else if (width_q < WMAX) begin
            width_d = width_q + 1'b1;
          end
        end
        S_OVER: begin
          if (fall_l) begin
            state_d  = S_IDLE;
            width_d  = '0;
            reject_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    always_ff @(posedge adc_clk) begin
      if (!rst) begin
        state_q  <= S_IDLE;
        width_q  <= '0;
        vgl_q    <= 1'b0;
        vgh_q    <= 1'b0;
        valid_q  <= 1'b0;
        reject_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        state_q  <= state_d;
        width_q  <= width_d;
        valid_q  <= valid_d;
        reject_q <= reject_d;
        if (rise_l)      vgl_q <= 1'b1;
        else if (fall_l) vgl_q <= 1'b0;
        if (rise_h)      vgh_q <= 1'b1;
        else if (fall_h) vgh_q <= 1'b0;
        // Clear wins over a coincident increment.
        if (clr_cnt)                cnt_q <= '0;
        else if (valid_d && ~&cnt_q) cnt_q <= cnt_q + 1'b1;
      end
    end

    assign vgl[c]        = vgl_q;
    assign vgh[c]        = vgh_q;
    assign evt_valid[c]  = valid_q;
    assign evt_reject[c] = reject_q;
    assign evt_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;

`ifdef WD_PEAK_CAPTURE_EN
    logic signed [ADC_WIDTH-1:0] max_q, peak_q;

    always_ff @(posedge adc_clk) begin
      if (!rst) begin
        max_q  <= '0;
        peak_q <= '0;
      end else begin
        if (state_q == S_IDLE && state_d == S_PULSE)          max_q <= d_s;
        else if (state_q == S_PULSE && !fall_l && d_s > max_q) max_q <= d_s;
        if (valid_d) peak_q <= max_q;
      end
    end

    assign peak[c*ADC_WIDTH +: ADC_WIDTH] = peak_q;
`else
    assign peak[c*ADC_WIDTH +: ADC_WIDTH] = '0;
`endif
  end

endmodule
